// File: rtl/hello_pkg.sv
// Shared types and message ROM for the HELLO scroll sequencer.
package hello_pkg;

    typedef enum logic [3:0] {
        H     = 4'h0,
        E     = 4'h1,
        L     = 4'h2,
        O     = 4'h3,
        BLANK = 4'hF
    } char_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } ctrl_state_t;

    localparam int MSG_ROM_LEN = 8;

    localparam char_t MSG [MSG_ROM_LEN] = '{H, E, L, L, O, BLANK, BLANK, BLANK};

endpackage

// File: rtl/scroll_prescaler.sv
// Free-running divider for the scroll rate; the count holds while run is low.
module scroll_prescaler #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Clears the display chain with blanks, then shifts the message in at the prescaled rate.
module hello_scroll_ctrl
    import hello_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 25000000,
    parameter int MSG_LEN    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       abort,
    output logic       shift_en,
    output logic [3:0] shift_in,
    output logic       busy,
    output logic [1:0] state_o
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int IW = $clog2(MSG_LEN);
    localparam logic [CW-1:0] CLR_LAST = CW'(NUM_DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(MSG_LEN - 1);

    ctrl_state_t   state;
    logic [CW-1:0] clr_cnt;
    logic [IW-1:0] char_idx;
    logic          tick;
    logic          pre_run;
    logic          pre_clr;

    // The prescaler only advances in RUN cycles that are not being stopped or aborted.
    assign pre_run = (state == RUN) && !stop && !abort;
    assign pre_clr = abort || (state == IDLE) || (state == CLEAR);

    scroll_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (pre_run),
        .clr   (pre_clr),
        .tick  (tick)
    );

    assign state_o = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            shift_en <= 1'b0;
            shift_in <= BLANK;
            clr_cnt  <= '0;
            char_idx <= '0;
        end else if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            shift_en <= 1'b0;
            shift_in <= BLANK;
            clr_cnt  <= '0;
            char_idx <= '0;
        end else begin
            shift_en <= 1'b0;
            shift_in <= BLANK;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        shift_en <= 1'b1;
                        clr_cnt  <= CW'(1);
                    end
                end
                CLEAR: begin
                    // clr_cnt counts blanks already issued; the last one hands over to RUN.
                    if (clr_cnt == CLR_LAST) begin
                        state    <= RUN;
                        clr_cnt  <= '0;
                        char_idx <= '0;
                    end else begin
                        shift_en <= 1'b1;
                        clr_cnt  <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= PAUSE;
                    end else if (tick) begin
                        shift_en <= 1'b1;
                        shift_in <= MSG[char_idx];
                        char_idx <= (char_idx == IDX_LAST) ? '0 : char_idx + 1'b1;
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hello_scroll_ctrl.md
Name: hello_scroll_ctrl

Overview:
Sequencer for the display register chain: NUM_DIGITS 4-bit character registers wired as a shift chain, each driving one 7-segment decoder. The block clears the chain, then shifts message characters in at a prescaled rate so "HELLO" scrolls across the displays. It only issues shift strobes and shift data. It sits between the board switches/keys and the register chain.

Parameters:
NUM_DIGITS, 6, number of 4-bit registers in the chain; clear-phase length in cycles.
TICK_DIV, 25000000, clk cycles per scroll step, minimum 2.
MSG_LEN, 8, characters in the message ROM: H,E,L,L,O,BLANK,BLANK,BLANK.

Ports:
clk  input  1  system clock, all state on posedge.
reset  input  1  asynchronous, active-low; clears all state immediately.
start  input  1  level; begin from IDLE or resume from PAUSE.
stop  input  1  level; pause scrolling.
abort  input  1  level; return to IDLE from any state.
shift_en  output  1  one-cycle strobe; the chain shifts when high.
shift_in  output  4  character code into the chain head, valid when shift_en=1.
busy  output  1  high in CLEAR, RUN and PAUSE.
state_o  output  2  encoded FSM state for debug and LEDs.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift_en=0, shift_in=BLANK, busy=0, char_idx=0, clr_cnt=0, prescaler=0.
- States: IDLE=0, CLEAR=1, RUN=2, PAUSE=3. All outputs are registered.
- Input priority each cycle: abort > stop > start.
- IDLE: start=1 -> CLEAR next cycle. stop has no effect.
- CLEAR: shift_en=1 and shift_in=BLANK on each of exactly NUM_DIGITS consecutive cycles, using clr_cnt 0..NUM_DIGITS-1. After the last strobe -> RUN with prescaler=0 and char_idx=0. stop has no effect here; the clear always completes.
- RUN: the prescaler counts 0..TICK_DIV-1.
  - At terminal count TICK_DIV-1: shift_en=1 for one cycle, shift_in=MSG[char_idx], prescaler wraps to 0.
  - char_idx increments and wraps from MSG_LEN-1 to 0.
  - The first character strobe comes TICK_DIV cycles after entering RUN.
- RUN with stop=1 -> PAUSE. The prescaler and char_idx freeze. No strobe in the cycle where stop is sampled, even at terminal count.
- PAUSE: shift_en=0. start=1 with stop=0 -> RUN, resuming from the frozen prescaler value. start and stop both 1 -> stay in PAUSE.
- abort=1 in any state -> IDLE next cycle. shift_en forced 0, counters cleared, and the chain is left as is (not cleared).
- shift_en is 0 in every cycle not listed above. shift_in holds BLANK when not strobing.
- busy = (state != IDLE).
- Counter widths: prescaler $clog2(TICK_DIV); clr_cnt $clog2(NUM_DIGITS+1); char_idx $clog2(MSG_LEN).
- reset deasserting mid-scroll restarts in IDLE. A new start is needed.

Decomposition:
- Package hello_pkg holds:
  - char_t enum, 4-bit: H=0, E=1, L=2, O=3, BLANK=4'hF.
  - ctrl_state_t enum, 2-bit, with the encodings above.
  - MSG constant array of char_t.
- Sub-module scroll_prescaler (parameter TICK_DIV):
  - inputs clk, reset, run, clr.
  - output tick: one-cycle pulse at terminal count; holds its count while run=0.

Test Plan:
Use NUM_DIGITS=4, TICK_DIV=4, MSG_LEN=8 for all scenarios.
- Reset then start pulse -> shift_en=1 with shift_in=4'hF for exactly cycles 1-4 after start sampled; busy=1 from cycle 1; state_o=2 at cycle 5.
- Free run 40 cycles -> one strobe every 4 cycles; shift_in sequence 0,1,2,2,3,F,F,F,0,1; char_idx wraps after the 8th strobe.
- stop asserted on the terminal-count cycle -> no strobe, state_o=3. Release stop, start 1 cycle -> next strobe 1 cycle later (prescaler resumed at 3) with the next character.
- start and stop high together in PAUSE -> stays in PAUSE. Both high in RUN -> PAUSE.
- abort during CLEAR after 2 strobes -> state_o=0, shift_en=0 next cycle. A subsequent start performs the full 4-cycle clear.
- reset pulled low asynchronously mid-RUN (between clock edges) -> outputs at reset values immediately. After release, no strobes until start.
